// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM state encodings, HILO bus geometry and small helpers.
package ex_mdu_pkg;

  localparam int HILO_BUS_WD = 66;
  localparam int DIV_CYCLES  = 32;
  localparam int DIV_CNT_W   = $clog2(DIV_CYCLES);

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DONE    = 2'd2
  } mdu_state_e;

  // Packs the HI/LO write data and enables into the EX->MEM bus layout.
  function automatic logic [HILO_BUS_WD-1:0] pack_hilo(
    input logic [31:0] hi_wdata,
    input logic [31:0] lo_wdata,
    input logic        hi_we,
    input logic        lo_we
  );
    return {hi_wdata, lo_wdata, hi_we, lo_we};
  endfunction

  // Two's-complement magnitude; the most negative value maps to itself,
  // which the unsigned divider then treats as 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB
// first. The 64-bit partial register holds {remainder, dividend/quotient}.
module div_core
  import ex_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_CYCLES - 1);

  logic [63:0]          part_q;
  logic [63:0]          part_next;
  logic [31:0]          divisor_q;
  logic [DIV_CNT_W-1:0] count_q;
  logic                 busy_q;
  logic [32:0]          trial;
  logic                 step_ge;
  logic [31:0]          step_diff;

  // One restoring step: shift left, trial-subtract, keep the difference if it fits.
  always_comb begin
    trial     = part_q[63:31];
    step_ge   = trial >= {1'b0, divisor_q};
    step_diff = trial[31:0] - divisor_q;
    part_next = step_ge ? {step_diff, part_q[30:0], 1'b1} : {part_q[62:0], 1'b0};
  end

  // Operand capture on start, iteration while busy, full clear on cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      part_q    <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else if (cancel) begin
      part_q    <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else if (start) begin
      part_q    <= {32'd0, dividend};
      divisor_q <= divisor;
      count_q   <= '0;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      part_q <= part_next;
      if (count_q == LAST_STEP) begin
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        count_q <= count_q + DIV_CNT_W'(1);
      end
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (count_q == LAST_STEP);
  assign quotient  = part_q[31:0];
  assign remainder = part_q[63:32];

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit. Multiplies and MTHI/MTLO resolve in one
// cycle; divides stall EX while div_core iterates, then present a
// sign-corrected result until the pipeline is free to take it.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mdu_op,
  input  logic [31:0]            src_a,
  input  logic [31:0]            src_b,
  input  logic                   ex_hold,
  input  logic                   cancel,
  output logic                   stallreq_for_ex,
  output logic [HILO_BUS_WD-1:0] hilo_ex_to_mem_bus
);

  mdu_state_e  state_q;
  mdu_state_e  state_next;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        is_div_op;
  logic        div_signed;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_quot;
  logic [31:0] core_rem;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign is_div_op  = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
  assign div_signed = (mdu_op == MDU_DIV);
  assign div_start  = (state_q == ST_IDLE) && is_div_op && !cancel;
  assign div_a      = div_signed ? abs32(src_a) : src_a;
  assign div_b      = div_signed ? abs32(src_b) : src_b;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  assign quot_fixed = q_neg_q ? (~core_quot + 32'd1) : core_quot;
  assign rem_fixed  = r_neg_q ? (~core_rem + 32'd1) : core_rem;

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (cancel),
    .dividend  (div_a),
    .divisor   (div_b),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

  // Result signs captured at start; a zero divisor keeps the all-ones quotient unnegated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (cancel) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (div_start) begin
      q_neg_q <= div_signed && (src_a[31] ^ src_b[31]) && (src_b != 32'd0);
      r_neg_q <= div_signed && src_a[31];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic: cancel always returns to IDLE; DONE waits for the pipeline.
  always_comb begin
    state_next = state_q;
    if (cancel) begin
      state_next = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (div_start) state_next = ST_DIV_RUN;
        ST_DIV_RUN: begin
          if (core_done) begin
            state_next = ST_DONE;
          end else if (!core_busy) begin
            state_next = ST_IDLE;
          end
        end
        ST_DONE:    if (!ex_hold) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: silent in reset or on cancel, otherwise by state and op.
  always_comb begin
    stallreq_for_ex    = 1'b0;
    hilo_ex_to_mem_bus = '0;
    if (rst && !cancel) begin
      case (state_q)
        ST_IDLE: begin
          case (mdu_op)
            MDU_NONE:  ;
            MDU_MULT:  hilo_ex_to_mem_bus = pack_hilo(prod_s[63:32], prod_s[31:0], 1'b1, 1'b1);
            MDU_MULTU: hilo_ex_to_mem_bus = pack_hilo(prod_u[63:32], prod_u[31:0], 1'b1, 1'b1);
            MDU_MTHI:  hilo_ex_to_mem_bus = pack_hilo(src_a, 32'd0, 1'b1, 1'b0);
            MDU_MTLO:  hilo_ex_to_mem_bus = pack_hilo(32'd0, src_a, 1'b0, 1'b1);
            MDU_DIV,
            MDU_DIVU:  stallreq_for_ex = 1'b1;
            default:   ;
          endcase
        end
        ST_DIV_RUN: stallreq_for_ex = 1'b1;
        ST_DONE:    hilo_ex_to_mem_bus = pack_hilo(rem_fixed, quot_fixed, 1'b1, 1'b1);
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: table of single-cycle ops, plus a
// scoreboard of divide results checked when the stall request drops.
module tb_ex_mdu;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int         STALL_CYCLES = 33;

  logic        clk;
  logic        rst;
  logic [2:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        ex_hold;
  logic        cancel;
  logic        stallreq_for_ex;
  logic [65:0] hilo_ex_to_mem_bus;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cncl;
    logic        exp_stall;
    logic [65:0] exp_bus;
  } vec_t;

  typedef struct {
    string       name;
    logic [65:0] bus;
  } sb_entry_t;

  vec_t      vecs[12];
  sb_entry_t sb[$];
  int        err_count;
  int        check_count;

  ex_mdu dut (
    .clk                (clk),
    .rst                (rst),
    .mdu_op             (mdu_op),
    .src_a              (src_a),
    .src_b              (src_b),
    .ex_hold            (ex_hold),
    .cancel             (cancel),
    .stallreq_for_ex    (stallreq_for_ex),
    .hilo_ex_to_mem_bus (hilo_ex_to_mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divide: plain SV arithmetic plus the architected corner cases.
  function automatic logic [63:0] divModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (op == OP_DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cncl);
    @(posedge clk);
    #1;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    cancel = cncl;
  endtask

  task automatic checkOutput(input string name, input logic exp_stall, input logic [65:0] exp_bus);
    check_count++;
    if (stallreq_for_ex !== exp_stall || hilo_ex_to_mem_bus !== exp_bus) begin
      err_count++;
      $display("[TB] FAIL %s: got stall=%0b bus=%h, expected stall=%0b bus=%h",
               name, stallreq_for_ex, hilo_ex_to_mem_bus, exp_stall, exp_bus);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Starts a divide, scrambles operands while it runs, counts stall cycles,
  // then checks the result (and keeps it under ex_hold for hold_cycles).
  task automatic runDiv(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int hold_cycles);
    int        stall_cycles;
    bit        finished;
    sb_entry_t exp;
    applyStimulus(op, a, b, 1'b0);
    sb.push_back('{name, {exp_hi, exp_lo, 2'b11}});
    stall_cycles = 0;
    finished     = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stallreq_for_ex) begin
        finished = 1'b1;
        break;
      end
      stall_cycles++;
      applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    end
    checkValue({name, " stall cycles"}, stall_cycles, STALL_CYCLES);
    exp = sb.pop_front();
    if (finished) begin
      checkOutput({exp.name, " result"}, 1'b0, exp.bus);
      if (hold_cycles > 0) begin
        ex_hold = 1'b1;
        for (int k = 1; k <= hold_cycles; k++) begin
          @(posedge clk);
          #1;
          if (k == hold_cycles) ex_hold = 1'b0;
          @(negedge clk);
          checkOutput($sformatf("%s hold %0d", exp.name, k), 1'b0, exp.bus);
        end
      end
    end else begin
      check_count++;
      err_count++;
      $display("[TB] FAIL %s result: stall never dropped, expected result bus=%h", exp.name, exp.bus);
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    err_count   = 0;
    check_count = 0;

    vecs[0]  = '{"mult neg",      OP_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFA, 2'b11}};
    vecs[1]  = '{"multu big",     OP_MULTU, 32'hFFFFFFFE, 32'd3,        1'b0, 1'b0, {32'h00000002, 32'hFFFFFFFA, 2'b11}};
    vecs[2]  = '{"mult 7x-5",     OP_MULT,  32'd7,        32'hFFFFFFFB, 1'b0, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFDD, 2'b11}};
    vecs[3]  = '{"multu max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, {32'hFFFFFFFE, 32'h00000001, 2'b11}};
    vecs[4]  = '{"mult minsq",    OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0, {32'h40000000, 32'h00000000, 2'b11}};
    vecs[5]  = '{"mult zero",     OP_MULT,  32'd0,        32'h1234,     1'b0, 1'b0, {32'h0,        32'h0,        2'b11}};
    vecs[6]  = '{"mthi",          OP_MTHI,  32'h12345678, 32'hDEAD,     1'b0, 1'b0, {32'h12345678, 32'h0,        2'b10}};
    vecs[7]  = '{"mtlo",          OP_MTLO,  32'hCAFEF00D, 32'hBEEF,     1'b0, 1'b0, {32'h0,        32'hCAFEF00D, 2'b01}};
    vecs[8]  = '{"none",          OP_NONE,  32'h11111111, 32'h22222222, 1'b0, 1'b0, 66'd0};
    vecs[9]  = '{"op7",           3'd7,     32'h33333333, 32'h44444444, 1'b0, 1'b0, 66'd0};
    vecs[10] = '{"mult cancel",   OP_MULT,  32'd5,        32'd6,        1'b1, 1'b0, 66'd0};
    vecs[11] = '{"div cancel",    OP_DIV,   32'd10,       32'd2,        1'b1, 1'b0, 66'd0};

    rst     = 1'b0;
    ex_hold = 1'b0;
    cancel  = 1'b0;
    mdu_op  = OP_MULT;
    src_a   = 32'd3;
    src_b   = 32'd5;
    #2;
    checkOutput("reset mult masked", 1'b0, 66'd0);
    mdu_op = OP_NONE;
    @(negedge clk);
    checkOutput("reset idle", 1'b0, 66'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cncl);
      @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_bus);
    end
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("no start after cancel", 1'b0, 66'd0);

    runDiv("div -7/2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    runDiv("divu 100/7", OP_DIVU, 32'd100,      32'd7, 32'd2,        32'd14,       0);
    runDiv("divu 5/0",   OP_DIVU, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 0);
    runDiv("div -5/0",   OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);

    // Cancel in the tenth RUN cycle, then a fresh divide.
    applyStimulus(OP_DIV, 32'hFFFFFF9C, 32'd7, 1'b0);
    @(negedge clk);
    checkOutput("cancel seq start", 1'b1, 66'd0);
    for (int k = 1; k < 10; k++) applyStimulus(OP_DIV, $urandom, $urandom, 1'b0);
    @(negedge clk);
    checkOutput("cancel seq run9", 1'b1, 66'd0);
    applyStimulus(OP_DIV, 32'd50, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("cancel seq cancel", 1'b0, 66'd0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("cancel seq idle", 1'b0, 66'd0);
    runDiv("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 0);

    // Held DONE, then a back-to-back overflow-style divide.
    runDiv("div 100/-7 held", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 4);
    runDiv("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
    runDiv("div min/0", OP_DIV, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF, 0);

    for (int i = 0; i < 4; i++) begin
      rop = (i % 2 == 0) ? OP_DIV : OP_DIVU;
      ra  = $urandom;
      rb  = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      m   = divModel(rop, ra, rb);
      runDiv($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb, m[63:32], m[31:0], 0);
    end

    // Reset asserted in the twentieth RUN cycle.
    applyStimulus(OP_DIV, 32'd1000, 32'd3, 1'b0);
    for (int k = 1; k < 20; k++) applyStimulus(OP_DIVU, $urandom, $urandom, 1'b0);
    @(negedge clk);
    checkOutput("reset seq run19", 1'b1, 66'd0);
    @(posedge clk);
    #1;
    mdu_op = OP_MULT;
    src_a  = 32'd3;
    src_b  = 32'd4;
    rst    = 1'b0;
    #1;
    checkOutput("reset seq immediate", 1'b0, 66'd0);
    @(negedge clk);
    checkOutput("reset seq held", 1'b0, 66'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset seq post mult", 1'b0, {32'd0, 32'd12, 2'b11});
    applyStimulus(OP_MTHI, 32'h12345678, 32'h9, 1'b0);
    @(negedge clk);
    checkOutput("reset seq mthi", 1'b0, {32'h12345678, 32'd0, 2'b10});
    m = divModel(OP_DIV, 32'd7, 32'hFFFFFFFE);
    runDiv("div 7/-2 after reset", OP_DIV, 32'd7, 32'hFFFFFFFE, m[63:32], m[31:0], 0);

    checkValue("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
